// File: rtl/fl8_to_int8_stream_pkg.sv
// Float8 {sign, exp[4:0], mant[1:0]} field definitions shared by the int8<->float8 casts.
// Holds the field widths, the bias, the decode classes and a field-split helper.
package fl8_to_int8_stream_pkg;

   localparam int FL8_W      = 8;
   localparam int FL8_EXP_W  = 5;
   localparam int FL8_MANT_W = 2;
   localparam int FL8_BIAS   = 15;
   localparam int FL8_SIG_W  = FL8_MANT_W + 1;
   localparam int SHIFT_W    = 4;
   localparam int SHIFT_MAX  = 9;
   localparam int INT8_W     = 8;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NEG,
      CLS_BIG,
      CLS_NORM
   } fl8_class_e;

   typedef struct packed {
      logic                  s;
      logic [FL8_EXP_W-1:0]  e;
      logic [FL8_MANT_W-1:0] m;
   } fl8_fields_t;

   function automatic fl8_fields_t fl8_split(input logic [FL8_W-1:0] raw);
      fl8_split = fl8_fields_t'(raw);
   endfunction

endpackage

// File: rtl/fl8_decode.sv
// Combinational float8 decode: result class, 3-bit significand and left-shift amount
// that places the value (with one guard bit) at bit 3 of the scaled significand.
module fl8_decode
   import fl8_to_int8_stream_pkg::*;
#(
   parameter int BIAS = FL8_BIAS
)
(
   input  logic [FL8_W-1:0]     fl8,
   output fl8_class_e           cls,
   output logic [FL8_SIG_W-1:0] sig,
   output logic [SHIFT_W-1:0]   shift
);

   localparam logic [FL8_EXP_W-1:0] E_BIG  = FL8_EXP_W'(BIAS + 8);
   localparam logic [FL8_EXP_W-1:0] E_HALF = FL8_EXP_W'(BIAS - 1);
   localparam logic [FL8_EXP_W-1:0] E_SH0  = FL8_EXP_W'(BIAS - 2);

   fl8_fields_t          f;
   logic [FL8_EXP_W-1:0] e_rel;

   assign f   = fl8_split(fl8);
   assign sig = {1'b1, f.m};

   // Exponent zero wins over sign so that -0 and negative denormals are unflagged.
   always_comb begin
      cls = CLS_NORM;
      if (f.e == '0)
         cls = CLS_ZERO;
      else if (f.s)
         cls = CLS_NEG;
      else if (f.e >= E_BIG)
         cls = CLS_BIG;
      else if (f.e < E_HALF)
         cls = CLS_ZERO;
   end

   always_comb begin
      e_rel = '0;
      shift = '0;
      if (f.e > E_SH0) begin
         e_rel = f.e - E_SH0;
         shift = (e_rel > FL8_EXP_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : SHIFT_W'(e_rel);
      end
   end

endmodule

// File: rtl/fl8_to_int8_stream.sv
// Two-stage float8 -> uint8 streaming converter with valid/ready on both sides,
// per-beat saturation flag and a sticky saturating event counter.
module fl8_to_int8_stream
   import fl8_to_int8_stream_pkg::*;
#(
   parameter int BIAS      = FL8_BIAS,
   parameter int SAT_CNT_W = 16
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FL8_W-1:0]     fl8_in,
   input  logic                 cast_,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INT8_W-1:0]    int8_out,
   output logic                 out_sat,
   input  logic                 sat_clr,
   output logic [SAT_CNT_W-1:0] sat_count
);

   localparam int SCALED_W = FL8_SIG_W + SHIFT_MAX;
   localparam int GUARD_W  = INT8_W + 1;

   logic                 s1_valid_reg;
   logic                 s2_valid_reg;
   logic                 s1_adv;
   logic                 s2_adv;

   logic                 s1_cast_reg;
   fl8_class_e           s1_cls_reg;
   logic [FL8_SIG_W-1:0] s1_sig_reg;
   logic [SHIFT_W-1:0]   s1_shift_reg;
   logic [FL8_W-1:0]     s1_raw_reg;

   fl8_class_e           dec_cls;
   logic [FL8_SIG_W-1:0] dec_sig;
   logic [SHIFT_W-1:0]   dec_shift;

   logic [SCALED_W-1:0]  scaled;
   logic [GUARD_W-1:0]   guard;
   logic [INT8_W-1:0]    int8_next;
   logic                 out_sat_next;
   logic [INT8_W-1:0]    int8_out_reg;
   logic                 out_sat_reg;

   logic [SAT_CNT_W-1:0] sat_count_reg;
   logic                 sat_inc;

   fl8_decode #(.BIAS(BIAS)) u_decode (
      .fl8   (fl8_in),
      .cls   (dec_cls),
      .sig   (dec_sig),
      .shift (dec_shift)
   );

   assign s2_adv    = ~s2_valid_reg | out_ready;
   assign s1_adv    = ~s1_valid_reg | s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_reg;
   assign int8_out  = int8_out_reg;
   assign out_sat   = out_sat_reg;
   assign sat_count = sat_count_reg;

   // scaled[11:3] is the magnitude with one guard bit; +1 then drop gives round half-up.
   always_comb begin
      scaled       = SCALED_W'(s1_sig_reg) << s1_shift_reg;
      guard        = GUARD_W'(scaled >> 3);
      int8_next    = s1_raw_reg;
      out_sat_next = 1'b0;
      if (s1_cast_reg) begin
         case (s1_cls_reg)
            CLS_ZERO: int8_next = '0;
            CLS_NEG: begin
               int8_next    = '0;
               out_sat_next = 1'b1;
            end
            CLS_BIG: begin
               int8_next    = '1;
               out_sat_next = 1'b1;
            end
            default: int8_next = INT8_W'((guard + GUARD_W'(1)) >> 1);
         endcase
      end
   end

   assign sat_inc = s2_valid_reg & out_ready & out_sat_reg & ~(&sat_count_reg);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         s1_cast_reg   <= 1'b0;
         s1_cls_reg    <= CLS_ZERO;
         s1_sig_reg    <= '0;
         s1_shift_reg  <= '0;
         s1_raw_reg    <= '0;
         int8_out_reg  <= '0;
         out_sat_reg   <= 1'b0;
         sat_count_reg <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
               s1_cast_reg  <= cast_;
               s1_cls_reg   <= dec_cls;
               s1_sig_reg   <= dec_sig;
               s1_shift_reg <= dec_shift;
               s1_raw_reg   <= fl8_in;
            end
         end
         if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               int8_out_reg <= int8_next;
               out_sat_reg  <= out_sat_next;
            end
         end
         // A clear in the same cycle as a counted transfer drops that event.
         if (sat_clr)
            sat_count_reg <= '0;
         else if (sat_inc)
            sat_count_reg <= sat_count_reg + SAT_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fl8_to_int8_stream.sv
// Self-checking bench for fl8_to_int8_stream: directed steps plus random streams
// checked against a real-arithmetic reference model and an output scoreboard.
module tb_fl8_to_int8_stream;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  fl8_in = 8'h00;
   logic        cast_ = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  int8_out;
   logic        out_sat;
   logic        sat_clr = 1'b0;
   logic [15:0] sat_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [7:0] val;
      logic       sat;
   } res_t;

   res_t        exp_q[$];
   logic [15:0] cnt_model = 16'h0000;

   fl8_to_int8_stream #(.BIAS(15), .SAT_CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fl8_in    (fl8_in),
      .cast_     (cast_),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .int8_out  (int8_out),
      .out_sat   (out_sat),
      .sat_clr   (sat_clr),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Value = (4+m) * 2^(e-17), rounded half-up; anything >= 256 clamps.
   function automatic res_t model(input logic [7:0] b, input logic c);
      res_t r;
      int   e;
      int   m;
      real  v;
      r.val = b;
      r.sat = 1'b0;
      if (!c) return r;
      e = {27'd0, b[6:2]};
      m = {30'd0, b[1:0]};
      r.val = 8'h00;
      if (e == 0) return r;
      if (b[7]) begin
         r.sat = 1'b1;
         return r;
      end
      v = 4.0 + m;
      for (int k = 17; k < e; k++) v = v * 2.0;
      for (int k = e; k < 17; k++) v = v / 2.0;
      if (v >= 256.0) begin
         r.val = 8'hFF;
         r.sat = 1'b1;
      end else begin
         r.val = 8'($rtoi(v + 0.5));
      end
      return r;
   endfunction

   // Input-layer int8 -> float8 cast (truncating mantissa).
   function automatic logic [7:0] int_to_fl8(input int n);
      int msb;
      int m;
      if (n == 0) return 8'h00;
      msb = 0;
      for (int k = 0; k < 8; k++) if (n >= (1 << k)) msb = k;
      m = (msb >= 2) ? ((n >> (msb - 2)) & 3) : ((n << (2 - msb)) & 3);
      return {1'b0, 5'(msb + 15), 2'(m)};
   endfunction

   // Scoreboard: observe at negedge what the next rising edge will transfer.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         cnt_model = 16'h0000;
      end else begin
         check("sat_count", sat_count, cnt_model);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
               check("out_data", int8_out, exp_q[0].val);
               check("out_sat", out_sat, exp_q[0].sat);
            end
         end
         if (sat_clr)
            cnt_model = 16'h0000;
         else if (out_valid && out_ready && exp_q.size() > 0 && exp_q[0].sat && cnt_model != 16'hFFFF)
            cnt_model = cnt_model + 16'd1;
         if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         if (in_valid && in_ready) exp_q.push_back(model(fl8_in, cast_));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_get(input logic [7:0] b, input logic c,
                           output logic [7:0] r, output logic s, output int lat);
      int w;
      r = 8'h00;
      s = 1'b0;
      lat = -1;
      in_valid = 1'b1;
      fl8_in = b;
      cast_ = c;
      out_ready = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!in_ready && w < 10);
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (out_valid) begin
            r = int8_out;
            s = out_sat;
            lat = k;
            break;
         end
      end
      tick();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] sw_in  [9] = '{8'h3C, 8'h38, 8'h37, 8'h41, 8'h5B, 8'h5C, 8'hBC, 8'h00, 8'h80};
      logic [7:0] sw_val [9] = '{8'd1, 8'd1, 8'd0, 8'd3, 8'd224, 8'd255, 8'd0, 8'd0, 8'd0};
      logic       sw_sat [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] bp     [4] = '{8'h5C, 8'h41, 8'hBC, 8'h3C};
      logic [7:0] r;
      logic       s;
      int         lat;
      int         acc;
      int         idx;
      logic       took;
      int         diff;
      int         step;
      int         msb;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid_after", out_valid, 1'b0);
      check("rst_int8_out", int8_out, 8'h00);
      check("rst_out_sat", out_sat, 1'b0);
      check("rst_sat_count", sat_count, 16'h0000);
      tick();

      // Convert sweep with latency
      for (int i = 0; i < 9; i++) begin
         send_get(sw_in[i], 1'b1, r, s, lat);
         check($sformatf("sweep_val_%02h", sw_in[i]), r, sw_val[i]);
         check($sformatf("sweep_sat_%02h", sw_in[i]), s, sw_sat[i]);
         check($sformatf("sweep_lat_%02h", sw_in[i]), lat, 2);
      end

      // Pass-through
      send_get(8'hA7, 1'b0, r, s, lat);
      check("pass_val", r, 8'hA7);
      check("pass_sat", s, 1'b0);

      // Random interleaved cast/pass stream with random backpressure
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         fl8_in    = 8'($urandom);
         cast_     = 1'($urandom);
         out_ready = ($urandom_range(2) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      check("rand_drain_empty", exp_q.size(), 0);

      // Backpressure: 4 beats offered with out_ready low
      sat_clr = 1'b1;
      tick();
      sat_clr   = 1'b0;
      out_ready = 1'b0;
      cast_     = 1'b1;
      in_valid  = 1'b1;
      idx = 0;
      acc = 0;
      fl8_in = bp[0];
      repeat (6) begin
         @(negedge clk);
         took = in_valid && in_ready;
         if (took) acc++;
         tick();
         if (took) begin
            idx++;
            if (idx < 4) fl8_in = bp[idx];
            else in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("bp_accepted", acc, 2);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_stalled_sat_count", sat_count, 16'h0000);
      tick();
      out_ready = 1'b1;
      for (int k = 0; k < 10 && idx < 4; k++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         tick();
         if (took) begin
            idx++;
            if (idx < 4) fl8_in = bp[idx];
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      repeat (4) tick();
      check("bp_drain_empty", exp_q.size(), 0);
      check("bp_sat_count", sat_count, 16'd2);

      // Three saturating beats
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      send_get(8'h5C, 1'b1, r, s, lat);
      send_get(8'hFF, 1'b1, r, s, lat);
      send_get(8'h60, 1'b1, r, s, lat);
      @(negedge clk);
      check("sat3_count", sat_count, 16'd3);
      tick();

      // sat_clr coincident with a saturating transfer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      fl8_in    = 8'hBC;
      cast_     = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      check("clr_stall_valid", out_valid, 1'b1);
      tick();
      sat_clr   = 1'b1;
      out_ready = 1'b1;
      tick();
      sat_clr = 1'b0;
      @(negedge clk);
      check("clr_coincident_count", sat_count, 16'h0000);
      check("clr_delivered", out_valid, 1'b0);
      tick();

      // Reset with two beats in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      fl8_in    = 8'h3C;
      tick();
      fl8_in = 8'h41;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_in_flight", out_valid, 1'b1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("mid_async_drop", out_valid, 1'b0);
      tick();
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("mid_in_ready", in_ready, 1'b1);
      check("mid_int8_out", int8_out, 8'h00);
      repeat (3) begin
         tick();
         @(negedge clk);
         check("mid_no_ghost", out_valid, 1'b0);
      end
      tick();
      send_get(8'h41, 1'b1, r, s, lat);
      check("mid_next_val", r, 8'd3);
      check("mid_next_lat", lat, 2);

      // Round trip through the input-layer cast
      send_get(int_to_fl8(200), 1'b1, r, s, lat);
      check("rt_200", r, 8'd192);
      for (int n = 0; n < 256; n++) begin
         send_get(int_to_fl8(n), 1'b1, r, s, lat);
         msb = 0;
         for (int k = 0; k < 8; k++) if (n >= (1 << k)) msb = k;
         step = (msb >= 2) ? (1 << (msb - 2)) : 0;
         diff = (int'(r) > n) ? (int'(r) - n) : (n - int'(r));
         check($sformatf("roundtrip_%0d", n), (diff <= step), 1'b1);
      end

      // Counter sticks at all-ones
      sat_clr = 1'b1;
      tick();
      sat_clr   = 1'b0;
      in_valid  = 1'b1;
      fl8_in    = 8'h7C;
      cast_     = 1'b1;
      out_ready = 1'b1;
      repeat (65540) tick();
      in_valid = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      check("sat_stick", sat_count, 16'hFFFF);
      check("final_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
